// File: rtl/ysyx_22041461_ifu.sv
// Instruction fetch unit: owns the PC, fetches one 32-bit word at a time from
// instruction memory, and hands it to decode. Downstream redirects discard stale fetches.
module ysyx_22041461_ifu #(
   parameter int unsigned        ADDR_W   = 64,
   parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h0000_0000_8000_0000)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // instruction memory request channel
   output logic              imem_req_valid_o,
   input  logic              imem_req_ready_i,
   output logic [ADDR_W-1:0] imem_req_addr_o,
   // instruction memory response channel (valid-only)
   input  logic              imem_resp_valid_i,
   input  logic [31:0]       imem_resp_data_i,
   input  logic              imem_resp_err_i,
   // decode interface
   output logic              inst_valid_o,
   input  logic              inst_ready_i,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] inst_pc_o,
   output logic [ADDR_W-1:0] inst_snpc_o,
   // redirect from downstream
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              fetch_err_o
);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StDrain,
      StHold,
      StHalt
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                err_q, err_d;
   logic                req_valid_q;
   logic [ADDR_W-1:0]   req_addr_q;
   logic                inst_valid_q;
   logic [31:0]         inst_q;
   logic [ADDR_W-1:0]   inst_pc_q;
   logic [ADDR_W-1:0]   snpc_q;

   // Next-state, next-pc and fault decode from the current state and inputs.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            state_d = StReq;
         end
         StReq: begin
            if (pc_q[1:0] != 2'b00) begin
               // Misaligned pc: never issue the request, park in HALT.
               err_d   = 1'b1;
               state_d = StHalt;
            end else begin
               if (redirect_valid_i) begin
                  pc_d = redirect_pc_i;
               end
               // An accepted request that is redirected in the same cycle is stale.
               if (imem_req_ready_i) begin
                  state_d = redirect_valid_i ? StDrain : StWait;
               end
            end
         end
         StWait: begin
            if (imem_resp_valid_i) begin
               if (imem_resp_err_i) begin
                  err_d   = 1'b1;
                  state_d = StHalt;
               end else if (redirect_valid_i) begin
                  // Response consumed here, so no drain is needed.
                  pc_d    = redirect_pc_i;
                  state_d = StReq;
               end else begin
                  state_d = StHold;
               end
            end else if (redirect_valid_i) begin
               pc_d    = redirect_pc_i;
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (redirect_valid_i) begin
               pc_d = redirect_pc_i;
            end
            if (imem_resp_valid_i) begin
               state_d = StReq;
            end
         end
         StHold: begin
            if (inst_ready_i) begin
               pc_d    = redirect_valid_i ? redirect_pc_i : pc_q + ADDR_W'(4);
               state_d = StReq;
            end else if (redirect_valid_i) begin
               pc_d    = redirect_pc_i;
               state_d = StReq;
            end
         end
         StHalt: begin
            err_d = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State, pc and registered outputs; outputs are derived from next state so they
   // are valid in the same cycle the FSM sits in the corresponding state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         err_q        <= 1'b0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         inst_pc_q    <= RESET_PC;
         snpc_q       <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         err_q        <= err_d;
         req_valid_q  <= (state_d == StReq) && (pc_d[1:0] == 2'b00);
         inst_valid_q <= (state_d == StHold);
         if (state_d == StReq) begin
            req_addr_q <= pc_d;
         end
         // HOLD is entered only from WAIT on a clean response.
         if ((state_q == StWait) && (state_d == StHold)) begin
            inst_q    <= imem_resp_data_i;
            inst_pc_q <= pc_q;
            snpc_q    <= pc_q + ADDR_W'(4);
         end
      end
   end

   assign imem_req_valid_o = req_valid_q;
   assign imem_req_addr_o  = req_addr_q;
   assign inst_valid_o     = inst_valid_q;
   assign inst_o           = inst_q;
   assign inst_pc_o        = inst_pc_q;
   assign inst_snpc_o      = snpc_q;
   assign fetch_err_o      = err_q;

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
// Directed bench for the fetch unit: boot, backpressure, redirects, faults and reset.
module tb_ysyx_22041461_ifu;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic [63:0] inst_snpc;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ysyx_22041461_ifu #(
      .ADDR_W   (64),
      .RESET_PC (64'h0000_0000_8000_0000)
   ) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .imem_req_valid_o  (imem_req_valid),
      .imem_req_ready_i  (imem_req_ready),
      .imem_req_addr_o   (imem_req_addr),
      .imem_resp_valid_i (imem_resp_valid),
      .imem_resp_data_i  (imem_resp_data),
      .imem_resp_err_i   (imem_resp_err),
      .inst_valid_o      (inst_valid),
      .inst_ready_i      (inst_ready),
      .inst_o            (inst),
      .inst_pc_o         (inst_pc),
      .inst_snpc_o       (inst_snpc),
      .redirect_valid_i  (redirect_valid),
      .redirect_pc_i     (redirect_pc),
      .fetch_err_o       (fetch_err)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      imem_resp_err   = 1'b0;
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;

      // Reset state
      step();
      step();
      check_eq("rst_req_valid", imem_req_valid, 0);
      check_eq("rst_inst_valid", inst_valid, 0);
      check_eq("rst_fetch_err", fetch_err, 0);
      check_eq("rst_req_addr", imem_req_addr, 0);
      check_eq("rst_inst", inst, 0);
      check_eq("rst_inst_pc", inst_pc, 64'h8000_0000);
      check_eq("rst_snpc", inst_snpc, 0);

      // Boot: IDLE -> REQ -> WAIT -> HOLD
      rst            = 1'b0;
      imem_req_ready = 1'b1;
      step();
      check_eq("boot_req_valid", imem_req_valid, 1);
      check_eq("boot_req_addr", imem_req_addr, 64'h8000_0000);
      check_eq("boot_iv0", inst_valid, 0);
      step();
      check_eq("boot_req_drop", imem_req_valid, 0);
      check_eq("boot_iv1", inst_valid, 0);
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0513;
      step();
      imem_resp_valid = 1'b0;
      check_eq("boot_iv", inst_valid, 1);
      check_eq("boot_inst", inst, 32'h0000_0513);
      check_eq("boot_pc", inst_pc, 64'h8000_0000);
      check_eq("boot_snpc", inst_snpc, 64'h8000_0004);

      // Backpressure for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("bp_iv", inst_valid, 1);
         check_eq("bp_inst", inst, 32'h0000_0513);
         check_eq("bp_pc", inst_pc, 64'h8000_0000);
         check_eq("bp_no_req", imem_req_valid, 0);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      check_eq("seq_req_valid", imem_req_valid, 1);
      check_eq("seq_req_addr", imem_req_addr, 64'h8000_0004);
      check_eq("seq_iv", inst_valid, 0);

      // Redirect while waiting, stale response two cycles later
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      step();
      redirect_valid = 1'b0;
      check_eq("drain_req", imem_req_valid, 0);
      check_eq("drain_iv", inst_valid, 0);
      step();
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hdead_beef;
      step();
      imem_resp_valid = 1'b0;
      check_eq("rdw_iv", inst_valid, 0);
      check_eq("rdw_req_valid", imem_req_valid, 1);
      check_eq("rdw_req_addr", imem_req_addr, 64'h8000_0100);

      // Redirect coincident with response
      step();
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1111_1111;
      redirect_valid  = 1'b1;
      redirect_pc     = 64'h8000_0200;
      step();
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      check_eq("coin_iv", inst_valid, 0);
      check_eq("coin_req_valid", imem_req_valid, 1);
      check_eq("coin_req_addr", imem_req_addr, 64'h8000_0200);
      step();
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0010_0093;
      step();
      imem_resp_valid = 1'b0;
      check_eq("coin_inst", inst, 32'h0010_0093);
      check_eq("coin_pc", inst_pc, 64'h8000_0200);
      check_eq("coin_snpc", inst_snpc, 64'h8000_0204);

      // Redirect in HOLD without consume, to the top of the address space
      redirect_valid = 1'b1;
      redirect_pc    = 64'hffff_ffff_ffff_fffc;
      step();
      redirect_valid = 1'b0;
      check_eq("hold_rd_iv", inst_valid, 0);
      check_eq("hold_rd_addr", imem_req_addr, 64'hffff_ffff_ffff_fffc);
      step();
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0073;
      step();
      imem_resp_valid = 1'b0;
      check_eq("wrap_inst", inst, 32'h0000_0073);
      check_eq("wrap_pc", inst_pc, 64'hffff_ffff_ffff_fffc);
      check_eq("wrap_snpc", inst_snpc, 64'h0);
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      check_eq("wrap_req_addr", imem_req_addr, 64'h0);
      check_eq("wrap_err", fetch_err, 0);

      // Access fault on response
      step();
      imem_resp_valid = 1'b1;
      imem_resp_err   = 1'b1;
      step();
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      inst_ready      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("err_flag", fetch_err, 1);
         check_eq("err_req", imem_req_valid, 0);
         check_eq("err_iv", inst_valid, 0);
         step();
      end
      inst_ready = 1'b0;

      // Reset clears the fault; misaligned redirect while request stalled
      rst = 1'b1;
      step();
      check_eq("rst2_err", fetch_err, 0);
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      step();
      check_eq("mis_req0", imem_req_valid, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0102;
      step();
      redirect_valid = 1'b0;
      check_eq("mis_req_valid", imem_req_valid, 0);
      check_eq("mis_err_pre", fetch_err, 0);
      imem_req_ready = 1'b1;
      step();
      check_eq("mis_err", fetch_err, 1);
      check_eq("mis_req_halt", imem_req_valid, 0);
      step();
      check_eq("mis_err_sticky", fetch_err, 1);
      check_eq("mis_iv", inst_valid, 0);

      // Reset in DRAIN with late response arriving during reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0400;
      step();
      redirect_valid = 1'b0;
      check_eq("rd_drain_req", imem_req_valid, 0);
      rst             = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hbad0_bad0;
      step();
      imem_resp_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check_eq("rmid_req_valid", imem_req_valid, 1);
      check_eq("rmid_req_addr", imem_req_addr, 64'h8000_0000);
      check_eq("rmid_err", fetch_err, 0);
      check_eq("rmid_iv", inst_valid, 0);
      step();
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0013;
      step();
      imem_resp_valid = 1'b0;
      check_eq("rmid_inst", inst, 32'h0000_0013);
      check_eq("rmid_pc", inst_pc, 64'h8000_0000);
      check_eq("rmid_iv1", inst_valid, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
